// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcode constants, skid-buffer states and immediate field types
// Purpose: common definitions for the IF->ID stage and its immediate slicer.
// Ports: none (package).
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        IMM_SEL_12 = 1'b0,
        IMM_SEL_20 = 1'b1
    } imm_sel_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [11:0] imm12;
        logic [19:0] imm20;
        imm_sel_e    imm_sel;
    } imm_fields_t;

    // True for every opcode the core decodes (includes inst[1:0]==2'b11).
    function automatic logic is_known_opcode(input logic [6:0] op);
        return (op == OP_LOAD)  || (op == OP_IMM)    || (op == OP_AUIPC) ||
               (op == OP_STORE) || (op == OP_OP)     || (op == OP_LUI)   ||
               (op == OP_BRANCH)|| (op == OP_JALR)   || (op == OP_SYSTEM)||
               (op == OP_JAL);
    endfunction

endpackage

// File: rtl/imm_field_extract.sv
// rtl/imm_field_extract.sv - combinational raw immediate field slicer feeding the Sign_Extender
// Purpose: pick the imm12/imm20 bit fields and the 12/20 select from a 32-bit instruction.
// Ports:
//   inst_i    in  32  instruction
//   fields_o  out     imm12, imm20, imm_sel (unused field forced to 0)
module imm_field_extract
    import rv32_pkg::*;
(
    input  logic [31:0] inst_i,
    output imm_fields_t fields_o
);

    always_comb begin
        fields_o = '{imm12: 12'd0, imm20: 20'd0, imm_sel: IMM_SEL_12};
        unique case (inst_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                fields_o.imm12 = inst_i[31:20];
            end
            OP_STORE: begin
                fields_o.imm12 = {inst_i[31:25], inst_i[11:7]};
            end
            OP_BRANCH: begin
                // Halfword offset; the consumer appends the implicit zero LSB.
                fields_o.imm12 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8]};
            end
            OP_LUI, OP_AUIPC: begin
                fields_o.imm20   = inst_i[31:12];
                fields_o.imm_sel = IMM_SEL_20;
            end
            OP_JAL: begin
                fields_o.imm20   = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21]};
                fields_o.imm_sel = IMM_SEL_20;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_id_imm_stage.sv
// rtl/if_id_imm_stage.sv - IF->ID stage: two-entry skid buffer plus instruction field slicing
// Purpose: hold fetched inst/PC behind a valid/ready skid buffer and present register
//   indices and raw immediate fields from the head entry.
// Optional: ILLEGAL_OPCODE_CHK_EN adds the illegal output.
// Ports:
//   clk, rst (sync active-high), flush
//   in_valid/in_ready/in_inst/in_pc       upstream (fetch) handshake
//   out_valid/out_ready/out_inst/out_pc   downstream handshake
//   opcode, rd, rs1, rs2                  instruction fields of the head entry
//   imm12, imm20, imm_sel                 Sign_Extender inputs
//   illegal                               (ILLEGAL_OPCODE_CHK_EN only) unknown opcode flag
module if_id_imm_stage
    import rv32_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_SIZE-1:0] in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_SIZE-1:0] out_inst,
    output logic [XLEN-1:0]      out_pc,
    output logic [6:0]           opcode,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [11:0]          imm12,
    output logic [19:0]          imm20,
`ifdef ILLEGAL_OPCODE_CHK_EN
    output logic                 imm_sel,
    output logic                 illegal
`else
    output logic                 imm_sel
`endif
);

    skid_state_e          state_q, state_d;
    logic                 in_ready_q;
    logic [INST_SIZE-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [XLEN-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic                 in_acc, out_acc;
    imm_fields_t          fields;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_acc    = in_valid & in_ready_q;
    assign out_acc   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            // Redirect wins over any accept on either side this cycle.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_acc) begin
                    state_d     = ONE;
                    main_inst_d = in_inst;
                    main_pc_d   = in_pc;
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        main_inst_d = in_inst;
                        main_pc_d   = in_pc;
                    end else if (in_acc) begin
                        state_d     = FULL;
                        skid_inst_d = in_inst;
                        skid_pc_d   = in_pc;
                    end else if (out_acc) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_acc) begin
                    state_d     = ONE;
                    main_inst_d = skid_inst_q;
                    main_pc_d   = skid_pc_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            main_inst_q <= NOP_INST;
            main_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    imm_field_extract u_imm (
        .inst_i   (main_inst_q[31:0]),
        .fields_o (fields)
    );

    assign out_inst = main_inst_q;
    assign out_pc   = main_pc_q;
    assign opcode   = main_inst_q[6:0];
    assign rd       = main_inst_q[11:7];
    assign rs1      = main_inst_q[19:15];
    assign rs2      = main_inst_q[24:20];
    assign imm12    = fields.imm12;
    assign imm20    = fields.imm20;
    assign imm_sel  = fields.imm_sel;

`ifdef ILLEGAL_OPCODE_CHK_EN
    assign illegal = out_valid &
                     (!is_known_opcode(main_inst_q[6:0]) || (main_inst_q[1:0] != 2'b11));
`endif

endmodule

// File: tb/tb_if_id_imm_stage.sv
// tb/tb_if_id_imm_stage.sv - self-checking bench for the IF->ID skid/immediate stage
module tb_if_id_imm_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, imm_sel;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm12;
    logic [19:0] imm20;
`ifdef ILLEGAL_OPCODE_CHK_EN
    logic        illegal;
`endif

    int nvec = 0;
    int nmis = 0;

    logic [63:0] q[$];
    bit          ready_m = 1'b0;

    always #5 clk = ~clk;

    if_id_imm_stage #(.XLEN(32), .INST_SIZE(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm12(imm12), .imm20(imm20),
`ifdef ILLEGAL_OPCODE_CHK_EN
        .imm_sel(imm_sel), .illegal(illegal)
`else
        .imm_sel(imm_sel)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural immediate of each format, reduced to the raw field the stage hands on.
    function automatic logic [32:0] exp_fields(input logic [31:0] inst);
        logic [12:0] boff;
        logic [20:0] joff;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return {inst[31:20], 20'd0, 1'b0};
            7'h23: return {inst[31:25], inst[11:7], 20'd0, 1'b0};
            7'h63: begin
                boff = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                return {boff[12:1], 20'd0, 1'b0};
            end
            7'h37, 7'h17: return {12'd0, inst[31:12], 1'b1};
            7'h6F: begin
                joff = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                return {12'd0, joff[20:1], 1'b1};
            end
            default: return 33'd0;
        endcase
    endfunction

    function automatic bit exp_known(input logic [31:0] inst);
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model of the stage as a bounded FIFO of depth 2, advanced once per clock edge.
    task automatic model_edge();
        bit pop, push;
        if (rst) begin
            q.delete();
            ready_m = 1'b0;
        end else if (flush) begin
            q.delete();
            ready_m = 1'b1;
        end else begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && ready_m;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({in_inst, in_pc});
            ready_m = (q.size() < 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        logic [31:0] hi, hp;
        chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
        chk("in_ready", {63'd0, in_ready}, {63'd0, ready_m});
        if (q.size() > 0) begin
            hi = q[0][63:32];
            hp = q[0][31:0];
            chk("out_inst", {32'd0, out_inst}, {32'd0, hi});
            chk("out_pc", {32'd0, out_pc}, {32'd0, hp});
            chk("fields", {15'd0, imm12, imm20, imm_sel}, {15'd0, exp_fields(hi)});
            chk("regs", {42'd0, opcode, rd, rs1, rs2}, {42'd0, hi[6:0], hi[11:7], hi[19:15], hi[24:20]});
`ifdef ILLEGAL_OPCODE_CHK_EN
            chk("illegal", {63'd0, illegal}, {63'd0, !exp_known(hi)});
        end else begin
            chk("illegal_idle", {63'd0, illegal}, 64'd0);
`endif
        end
    end

    task automatic fmt(input logic [31:0] inst, input logic [11:0] e12,
                       input logic [19:0] e20, input logic esel);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = in_pc + 32'd4;
        tick();
        chk("fmt_valid", {63'd0, out_valid}, 64'd1);
        chk("fmt_fields", {31'd0, imm12, imm20, imm_sel}, {31'd0, e12, e20, esel});
    endtask

    logic [31:0] pool [8];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0;

        // Reset
        tick(); tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_inst", {32'd0, out_inst}, 64'h13);
        chk("rst_pc_imm", {19'd0, out_pc, imm12, imm_sel}, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Streaming
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
        tick();
        chk("addi_valid", {63'd0, out_valid}, 64'd1);
        chk("addi_imm", {50'd0, imm12, imm_sel, rd}, {50'd0, 12'hFFF, 1'b0, 5'd1});
        chk("addi_pc", {32'd0, out_pc}, 64'h100);
        in_inst = 32'h000012B7; in_pc = 32'h104;
        tick();
        chk("lui_imm", {38'd0, imm20, imm_sel, rd}, {38'd0, 20'h00001, 1'b1, 5'd5});
        in_valid = 1'b0;
        tick();

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500113; in_pc = 32'h200;
        tick();
        in_inst = 32'h00A00193; in_pc = 32'h204;
        tick();
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_head", {32'd0, out_inst}, 64'h00500113);
        in_inst = 32'h00F00213; in_pc = 32'h208;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("bp_hold", {20'd0, out_inst, imm12}, {20'd0, 32'h00500113, 12'h005});
        out_ready = 1'b1;
        tick();
        chk("bp_second", {32'd0, out_inst}, 64'h00A00193);
        tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Immediate formats
        in_pc = 32'h3FC;
        fmt(32'hFE112E23, 12'hFFC, 20'd0, 1'b0);
        fmt(32'hFE000EE3, 12'hFFE, 20'd0, 1'b0);
        fmt(32'hFFDFF0EF, 12'd0, 20'hFFFFE, 1'b1);
        fmt(32'h02208033, 12'd0, 20'd0, 1'b0);
        fmt(32'h0000007F, 12'd0, 20'd0, 1'b0);
`ifdef ILLEGAL_OPCODE_CHK_EN
        chk("illegal_hi", {63'd0, illegal}, 64'd1);
        fmt(32'h00000013, 12'd0, 20'd0, 1'b0);
        chk("illegal_lo", {63'd0, illegal}, 64'd0);
`endif
        in_valid = 1'b0;
        tick();

        // Flush while FULL with a simultaneous input
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h500;
        tick();
        in_inst = 32'h00200093; in_pc = 32'h504;
        tick();
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00300093; in_pc = 32'h508;
        tick();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();
        chk("flush_gone", {63'd0, out_valid}, 64'd0);

        // Reset mid-transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00400093; in_pc = 32'h600;
        tick();
        rst = 1'b1; in_inst = 32'h00500093; in_pc = 32'h604;
        tick();
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("mrst_after", {62'd0, in_ready, out_valid}, 64'd2);

        // Mixed traffic checked against the model every cycle
        pool[0] = 32'hFFF00093; pool[1] = 32'h000012B7; pool[2] = 32'hFE112E23;
        pool[3] = 32'hFE000EE3; pool[4] = 32'hFFDFF0EF; pool[5] = 32'h02208033;
        pool[6] = 32'h0000007F; pool[7] = 32'h12345017;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_inst   = pool[$urandom_range(0, 7)] ^ {$urandom_range(0, 255), 12'd0};
            in_pc     = 32'h1000 + 32'(i) * 4;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
